// File: rtl/vga_ctrl_pkg.sv
// Shared VGA timing defaults and scan-decode types for the scan-out controller.
// Used by vga_timing (counters/decode) and vga_ctrl (pipeline/addressing).
package vga_ctrl_pkg;

  localparam int H_ACTIVE_DEF    = 640;
  localparam int H_FP_DEF        = 16;
  localparam int H_SYNC_DEF      = 96;
  localparam int H_BP_DEF        = 48;
  localparam int H_TOTAL_DEF     = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF    = 480;
  localparam int V_FP_DEF        = 10;
  localparam int V_SYNC_DEF      = 2;
  localparam int V_BP_DEF        = 33;
  localparam int V_TOTAL_DEF     = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CLK_DIV_DEF     = 2;
  localparam int SCALE_SHIFT_DEF = 2;
  localparam int FB_AW_DEF       = 15;

  // Decoded view of the current scan position.
  typedef struct packed {
    logic active;
    logic hs;
    logic vs;
  } scan_t;

  localparam scan_t SCAN_IDLE = '{active: 1'b0, hs: 1'b1, vs: 1'b1};

  // Active-low sync level: low only inside [start, start+width).
  function automatic logic sync_level(input int cnt, input int start, input int width);
    return !(cnt >= start && cnt < start + width);
  endfunction

endpackage

// File: rtl/vga_ctrl_if.sv
// Framebuffer read port and VGA pin bundle of the scan-out controller.
interface vga_ctrl_if #(
  parameter int FB_AW = 15
);
  // No handshake: the controller drives fb_addr and the RAM must return
  // fb_rdata for that address exactly one clk later, unconditionally.
  logic [FB_AW-1:0] fb_addr;
  logic [2:0]       fb_rdata;
  logic [2:0]       vga_rgb;
  logic             vga_hsync;
  logic             vga_vsync;
  logic             frame_start;

  modport master (
    output fb_addr,
    input  fb_rdata,
    output vga_rgb,
    output vga_hsync,
    output vga_vsync,
    output frame_start
  );

  modport slave (
    input  fb_addr,
    output fb_rdata,
    input  vga_rgb,
    input  vga_hsync,
    input  vga_vsync,
    input  frame_start
  );
endinterface

// File: rtl/vga_timing.sv
// Pixel-clock divider, horizontal/vertical scan counters and the
// active/hsync/vsync decode of the current counter position.
module vga_timing
  import vga_ctrl_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int CLK_DIV  = CLK_DIV_DEF,
  parameter int HW       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1),
  parameter int VW       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  output logic          pix_en,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output scan_t         scan
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);

  logic [DW-1:0] div_cnt;

  // With CLK_DIV==1 div_cnt stays 0 and every clk is a pixel.
  assign pix_en = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else if (pix_en) begin
      div_cnt <= '0;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    scan        = SCAN_IDLE;
    scan.active = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
    scan.hs     = sync_level(int'(h_cnt), H_ACTIVE + H_FP, H_SYNC);
    scan.vs     = sync_level(int'(v_cnt), V_ACTIVE + V_FP, V_SYNC);
  end

endmodule

// File: rtl/vga_ctrl.sv
// VGA scan-out controller: two-stage pixel pipeline (address, then colour/sync)
// over a scaled framebuffer, plus a once-per-frame vsync-fall pulse.
module vga_ctrl
  import vga_ctrl_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_DEF,
  parameter int H_FP        = H_FP_DEF,
  parameter int H_SYNC      = H_SYNC_DEF,
  parameter int H_BP        = H_BP_DEF,
  parameter int V_ACTIVE    = V_ACTIVE_DEF,
  parameter int V_FP        = V_FP_DEF,
  parameter int V_SYNC      = V_SYNC_DEF,
  parameter int V_BP        = V_BP_DEF,
  parameter int CLK_DIV     = CLK_DIV_DEF,
  parameter int SCALE_SHIFT = SCALE_SHIFT_DEF,
  parameter int FB_AW       = FB_AW_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  vga_ctrl_if.master bus
);

  localparam int HW   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1);
  localparam int VW   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1);
  localparam int FB_W = H_ACTIVE >> SCALE_SHIFT;

  logic          pix_en;
  logic [HW-1:0] h_cnt;
  logic [VW-1:0] v_cnt;
  scan_t         scan;

  vga_timing #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP),
    .CLK_DIV  (CLK_DIV),
    .HW       (HW),
    .VW       (VW)
  ) u_timing (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .pix_en (pix_en),
    .h_cnt  (h_cnt),
    .v_cnt  (v_cnt),
    .scan   (scan)
  );

  logic [FB_AW-1:0] addr_next;
  logic [FB_AW-1:0] addr_q;
  scan_t            scan_d1;
  logic [2:0]       rgb_q;
  logic             hsync_q;
  logic             vsync_q;
  logic             fs_q;

  // Store row = line >> shift, store column = pixel >> shift.
  always_comb begin
    addr_next = '0;
    if (scan.active) begin
      addr_next = FB_AW'((32'(v_cnt) >> SCALE_SHIFT) * 32'(FB_W)
                         + (32'(h_cnt) >> SCALE_SHIFT));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      scan_d1 <= SCAN_IDLE;
      rgb_q   <= 3'b000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
    end else if (!enable) begin
      addr_q  <= '0;
      scan_d1 <= SCAN_IDLE;
      rgb_q   <= 3'b000;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      // Fires on the same edge that drives vga_vsync low.
      fs_q <= pix_en && !scan_d1.vs && vsync_q;
      if (pix_en) begin
        addr_q  <= addr_next;
        scan_d1 <= scan;
        rgb_q   <= scan_d1.active ? bus.fb_rdata : 3'b000;
        hsync_q <= scan_d1.hs;
        vsync_q <= scan_d1.vs;
      end
    end
  end

  assign bus.fb_addr     = addr_q;
  assign bus.vga_rgb     = rgb_q;
  assign bus.vga_hsync   = hsync_q;
  assign bus.vga_vsync   = vsync_q;
  assign bus.frame_start = fs_q;

endmodule

// File: doc/vga_ctrl.md
# vga_ctrl

VGA scan-out controller for the SOC, sitting directly downstream of the CPU/framebuffer memory and driving the board pins `vga_rgb`, `vga_hsync` and `vga_vsync` of `soc_top`. It generates 640x480@60 timing from a divided system clock. It fetches 3-bit pixels from a synchronous-read framebuffer at 4x4 pixel scaling (160x120 store). It also emits a once-per-frame pulse the CPU uses as a vertical-blank event.

## Interface
Parameters:
- `H_ACTIVE` 640; `H_FP` 16; `H_SYNC` 96; `H_BP` 48: horizontal timing in pixels.
- `V_ACTIVE` 480; `V_FP` 10; `V_SYNC` 2; `V_BP` 33: vertical timing in lines.
- `CLK_DIV` 2: clk cycles per pixel (>=1).
- `SCALE_SHIFT` 2: log2 of pixel replication factor.
- `FB_AW` 15: framebuffer address width.

Ports:
- `clk` in 1: system clock; the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `enable` in 1: scan-out enable, synchronous.
- `fb_addr` out FB_AW: framebuffer read address (RAM returns data 1 clk later).
- `fb_rdata` in 3: pixel data from framebuffer.
- `vga_rgb` out 3: pixel colour, 0 during blanking.
- `vga_hsync` out 1: horizontal sync, active-low.
- `vga_vsync` out 1: vertical sync, active-low.
- `frame_start` out 1: one-clk pulse per frame.

## Operation
- Divider `div_cnt` counts 0..CLK_DIV-1. `pix_en` = (div_cnt==CLK_DIV-1).
- `h_cnt` counts 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800) and advances on `pix_en`. On wrap, `v_cnt` advances 0..V_TOTAL-1 (525) and wraps to 0.
- Decode from current counters:
  - active = h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
  - hs = !(H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC).
  - vs: same rule on `v_cnt`.
- Stage A, on `pix_en`:
  - If active: `fb_addr` <= (v_cnt>>SCALE_SHIFT)*(H_ACTIVE>>SCALE_SHIFT) + (h_cnt>>SCALE_SHIFT), truncated to FB_AW. Otherwise `fb_addr` <= 0.
  - hs_d1, vs_d1, act_d1 <= decoded values.
- Stage B, on the next `pix_en`:
  - `vga_rgb` <= act_d1 ? fb_rdata : 3'b000.
  - `vga_hsync` <= hs_d1; `vga_vsync` <= vs_d1.
- `frame_start` <= pix_en && vs_d1==0 && vga_vsync==1. It is high for exactly one clk, in the cycle where `vga_vsync` first reads low.
- `enable` low: in the next clk, all counters, pipeline registers and outputs take their reset values and hold there. `enable` rising restarts the scan from (h,v)=(0,0) with div_cnt=0.
- Reset values: div_cnt/h_cnt/v_cnt 0, `fb_addr` 0, `vga_rgb` 0, `vga_hsync` 1, `vga_vsync` 1, `frame_start` 0, hs_d1/vs_d1 1, act_d1 0.
- `reset` low mid-frame: all state goes to reset values immediately, with no clk edge needed.

## Timing
- Pixel period = CLK_DIV clks. `fb_rdata` is sampled CLK_DIV clks after `fb_addr` is updated; the RAM must have 1-clk read latency.
- Output latency is 2 pixel periods from counter to pins. Sync and rgb are mutually aligned.
- At defaults, with clk = 50 MHz:
  - hsync period 1600 clks, low 192 clks, low for h_cnt 656..751 (pre-latency).
  - vsync period 840000 clks, low 3200 clks, low for v_cnt 490..491.
- Each store pixel is repeated for 4 consecutive pixels and 4 consecutive lines.
- `enable` and `pix_en` coinciding: `enable` low wins.

## Structure
- Timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL) go in a shared VGA defines header, included alongside the CPU defines.
- One sub-module, `vga_timing`: divider, h/v counters, and active/hs/vs decode. Pipeline and address arithmetic stay in `vga_ctrl`.

## Test plan
- **Reset:** hold `reset` low, toggle clk.
  - Expect `vga_rgb`=000, syncs=1, `fb_addr`=0, `frame_start`=0.
  - Assert `reset` low between clk edges: outputs return to idle with no edge.
- **Horizontal timing:** release reset with enable=1.
  - `vga_hsync` low width 192 clks, period 1600 clks.
  - First falling edge at clk (656+2)*2 after release.
- **Vertical timing:**
  - `vga_vsync` low 3200 clks, period 840000 clks.
  - `frame_start` is a single-clk pulse coincident with the vsync fall, once per frame.
- **Addressing:** RAM model with 1-clk latency returning addr[2:0].
  - At pixel (h=8, v=4): `fb_addr`=162 and `vga_rgb`=010, 2 pixel periods later.
  - During blanking with `fb_rdata` forced to 111: `vga_rgb`=000.
- **Enable drop:** drop `enable` at h_cnt=300.
  - Next clk: outputs idle, counters 0.
  - Re-enable: first hsync fall again (656+2)*2 clks later.
- **Address range:** at last active pixel (639, 479), `fb_addr`=19199 with no truncation.
